// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: arbitrates stall/flush sources into one hold code + PC redirect.
// Ports: Clk/Rst, EX jump + mul/div busy, ID load-use, fetch ready, CLINT int req/ack, hold/jump/stall outs.
module pipe_hold_ctrl #(
  parameter int AW           = 32,
  parameter int HOLD_W       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              JumpFlagFromEx,
  input  logic [AW-1:0]     JumpAddrFromEx,
  input  logic              MulDivBusyFromEx,
  input  logic              LoadUseFromId,
  input  logic              InstReadyFromBus,
  input  logic              IntReqFromClint,
  input  logic [AW-1:0]     IntAddrFromClint,
  output logic              IntAckToClint,
  output logic [HOLD_W-1:0] HoldFlagOut,
  output logic              JumpFlagOut,
  output logic [AW-1:0]     JumpAddrOut,
  output logic [CNT_W-1:0]  StallCntOut
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  localparam logic [HOLD_W-1:0] H_NONE     = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] H_HOLD_PC  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] H_HOLD_IF  = HOLD_W'(2);
  localparam logic [HOLD_W-1:0] H_HOLD_ID  = HOLD_W'(3);
  localparam logic [HOLD_W-1:0] H_FLUSH_IF = HOLD_W'(4);
  localparam logic [HOLD_W-1:0] H_FLUSH_ID = HOLD_W'(5);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            int_pend;
  logic [CNT_W-1:0] stall_cnt;

  logic take_int;
  logic redirect;

  // Interrupt waits out any flush and any mul/div; a jump always wins.
  assign take_int = !JumpFlagFromEx && int_pend &&
                    (state == IDLE) && !MulDivBusyFromEx;
  assign redirect = JumpFlagFromEx || take_int;

  always_comb begin
    HoldFlagOut   = H_NONE;
    JumpFlagOut   = 1'b0;
    JumpAddrOut   = '0;
    IntAckToClint = 1'b0;
    if (JumpFlagFromEx) begin
      JumpFlagOut = 1'b1;
      JumpAddrOut = JumpAddrFromEx;
      HoldFlagOut = H_FLUSH_ID;
    end else if (take_int) begin
      JumpFlagOut   = 1'b1;
      JumpAddrOut   = IntAddrFromClint;
      HoldFlagOut   = H_FLUSH_ID;
      IntAckToClint = 1'b1;
    end else if (MulDivBusyFromEx) begin
      HoldFlagOut = H_HOLD_ID;
    end else if (state == FLUSH) begin
      HoldFlagOut = H_FLUSH_IF;
    end else if (LoadUseFromId) begin
      HoldFlagOut = H_HOLD_IF;
    end else if (!InstReadyFromBus) begin
      HoldFlagOut = H_HOLD_PC;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      int_pend  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (redirect) begin
        // Redirect costs FLUSH_CYCLES total; the first is the FLUSH_ID now.
        state <= (CNT_INIT != '0) ? FLUSH : IDLE;
        cnt   <= CNT_INIT;
      end else if (state == FLUSH && !MulDivBusyFromEx) begin
        if (cnt <= CW'(1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      int_pend <= take_int ? 1'b0 : (int_pend | IntReqFromClint);
      if (HoldFlagOut != H_NONE && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign StallCntOut = stall_cnt;

endmodule
